// File: rtl/wrra_weight_ctrl_if.sv
// Bus bundle for wrra_weight_ctrl: weight configuration, IVC requests and
// grants in; per-port and per-IVC consumed flags and pending status out.
interface wrra_weight_ctrl_if #(
  parameter int unsigned V       = 4,
  parameter int unsigned P       = 5,
  parameter int unsigned WEIGHTw = 4
);

  logic [P*WEIGHTw-1:0] weight_cfg_all;
  logic [P-1:0]         cfg_wr_en;
  logic [WEIGHTw-1:0]   vc_weight;
  logic [P*V-1:0]       ivc_request_all;
  logic [P*V-1:0]       ivc_num_getting_sw_grant;
  logic [P-1:0]         iport_weight_is_consumed_all;
  logic [P*V-1:0]       vc_weight_is_consumed_all;
  logic [P-1:0]         cfg_pending_all;

  // Allocator / configuration side
  modport master (
    output weight_cfg_all,
    output cfg_wr_en,
    output vc_weight,
    output ivc_request_all,
    output ivc_num_getting_sw_grant,
    input  iport_weight_is_consumed_all,
    input  vc_weight_is_consumed_all,
    input  cfg_pending_all
  );

  // Weight controller side
  modport slave (
    input  weight_cfg_all,
    input  cfg_wr_en,
    input  vc_weight,
    input  ivc_request_all,
    input  ivc_num_getting_sw_grant,
    output iport_weight_is_consumed_all,
    output vc_weight_is_consumed_all,
    output cfg_pending_all
  );

endinterface

// File: rtl/wrra_weight_ctrl.sv
// Weighted round-robin weight controller for a P-port, V-VC router.
// Tracks per-port and per-IVC grant counters against their weights and flags
// when the next grant closes a round. Port weight updates are shadowed and
// only take effect at a round boundary (or while the port sits at count 0).
// Optional feature: define WRRA_IDLE_RESET_EN to clear a port's counters
// (and apply any pending weight) after a cycle with no requests on that port.
module wrra_weight_ctrl #(
  parameter int unsigned V       = 4,
  parameter int unsigned P       = 5,
  parameter int unsigned WEIGHTw = 4
) (
  input logic               clk,
  input logic               reset,
  wrra_weight_ctrl_if.slave bus
);

  localparam int unsigned NV = P * V;

  typedef logic [WEIGHTw-1:0] weight_t;

  weight_t [P-1:0]  aw_q, aw_d;
  weight_t [P-1:0]  sw_q, sw_d;
  weight_t [P-1:0]  pc_q, pc_d;
  logic    [P-1:0]  pd_q, pd_d;
  weight_t [NV-1:0] vc_q, vc_d;

  logic    [P-1:0]  grant_any;
  logic    [P-1:0]  idle_rst;
  logic    [P-1:0]  port_cons;
  logic    [NV-1:0] vc_cons;
  weight_t          vc_ewm1;

  // Effective weight minus one: weight 0 behaves like weight 1
  function automatic weight_t ew_m1(input weight_t w);
    return (w == '0) ? '0 : w - WEIGHTw'(1);
  endfunction

`ifdef WRRA_IDLE_RESET_EN
  // A port with no requesting IVC this cycle restarts its rounds
  always_comb begin
    idle_rst = '0;
    for (int unsigned p = 0; p < P; p++) begin
      idle_rst[p] = ~(|bus.ivc_request_all[p*V +: V]);
    end
  end
`else
  // Requests only matter for idle restart; counters hold through idle cycles
  logic unused_req;
  assign unused_req = ^bus.ivc_request_all;
  assign idle_rst   = '0;
`endif

  // Grant summary per port and round-end decode from current registers
  always_comb begin
    grant_any = '0;
    port_cons = '0;
    vc_cons   = '0;
    vc_ewm1   = ew_m1(bus.vc_weight);
    for (int unsigned p = 0; p < P; p++) begin
      grant_any[p] = |bus.ivc_num_getting_sw_grant[p*V +: V];
      port_cons[p] = (pc_q[p] == ew_m1(aw_q[p]));
    end
    for (int unsigned i = 0; i < NV; i++) begin
      vc_cons[i] = (vc_q[i] == vc_ewm1);
    end
  end

  // Port next state: shadow write, counter advance, weight swap at boundary
  always_comb begin
    aw_d = aw_q;
    sw_d = sw_q;
    pd_d = pd_q;
    pc_d = pc_q;
    for (int unsigned p = 0; p < P; p++) begin
      if (bus.cfg_wr_en[p]) begin
        sw_d[p] = bus.weight_cfg_all[p*WEIGHTw +: WEIGHTw];
        pd_d[p] = 1'b1;
      end
      if (grant_any[p]) begin
        pc_d[p] = port_cons[p] ? '0 : pc_q[p] + WEIGHTw'(1);
      end
      if (idle_rst[p]) begin
        pc_d[p] = '0;
      end
      // A write landing on a boundary is taken at that boundary; an idle
      // port at count 0 absorbs an already-registered pending weight.
      if ((grant_any[p] && port_cons[p] && pd_d[p]) ||
          ((idle_rst[p] || (!grant_any[p] && (pc_q[p] == '0))) && pd_q[p])) begin
        aw_d[p] = sw_d[p];
        pd_d[p] = 1'b0;
        pc_d[p] = '0;
      end
      // Keep the counter inside the round of the (possibly new) weight
      if (pc_d[p] > ew_m1(aw_d[p])) begin
        pc_d[p] = '0;
      end
    end
  end

  // IVC counter next state; out-of-range counts (after a weight drop) clear
  always_comb begin
    vc_d = vc_q;
    for (int unsigned p = 0; p < P; p++) begin
      for (int unsigned v = 0; v < V; v++) begin
        if (vc_q[p*V+v] > vc_ewm1) begin
          vc_d[p*V+v] = '0;
        end else if (bus.ivc_num_getting_sw_grant[p*V+v]) begin
          vc_d[p*V+v] = vc_cons[p*V+v] ? '0 : vc_q[p*V+v] + WEIGHTw'(1);
        end
        if (idle_rst[p]) begin
          vc_d[p*V+v] = '0;
        end
      end
    end
  end

  // State registers; reset drops any pending weight and restores weight 1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned p = 0; p < P; p++) begin
        aw_q[p] <= WEIGHTw'(1);
        sw_q[p] <= WEIGHTw'(1);
        pc_q[p] <= '0;
      end
      pd_q <= '0;
      vc_q <= '0;
    end else begin
      aw_q <= aw_d;
      sw_q <= sw_d;
      pc_q <= pc_d;
      pd_q <= pd_d;
      vc_q <= vc_d;
    end
  end

  // Status outputs decoded straight from registers
  assign bus.iport_weight_is_consumed_all = port_cons;
  assign bus.vc_weight_is_consumed_all    = vc_cons;
  assign bus.cfg_pending_all              = pd_q;

endmodule

// File: tb/tb_wrra_weight_ctrl.sv
// Directed bench for wrra_weight_ctrl (V=4, P=5, WEIGHTw=4).
module tb_wrra_weight_ctrl;

  localparam int unsigned V  = 4;
  localparam int unsigned P  = 5;
  localparam int unsigned WW = 4;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  wrra_weight_ctrl_if #(.V(V), .P(P), .WEIGHTw(WW)) bus ();

  wrra_weight_ctrl #(.V(V), .P(P), .WEIGHTw(WW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 2 time units after the edge
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic write_w(input int unsigned p, input logic [WW-1:0] w);
    bus.weight_cfg_all[p*WW +: WW] = w;
    bus.cfg_wr_en = '0;
    bus.cfg_wr_en[p] = 1'b1;
  endtask

  logic pc0_cons_exp [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic vc0_cons_exp [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic p1_cons_exp  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic vc10_exp     [3] = '{1'b0, 1'b0, 1'b1};

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    bus.weight_cfg_all = '0;
    bus.cfg_wr_en = '0;
    bus.vc_weight = 4'd2;
    bus.ivc_request_all = '1;
    bus.ivc_num_getting_sw_grant = '0;

    // Reset state, with vc_weight visible through reset
    #3;
    check("rst_iport_cons", 32'(bus.iport_weight_is_consumed_all), 32'h1f);
    check("rst_vc_cons", 32'(bus.vc_weight_is_consumed_all), 32'h0);
    check("rst_pending", 32'(bus.cfg_pending_all), 32'h0);
    step();
    reset = 1'b1;
    step();
    check("post_rst_iport_cons", 32'(bus.iport_weight_is_consumed_all), 32'h1f);
    check("post_rst_vc_cons", 32'(bus.vc_weight_is_consumed_all), 32'h0);
    check("post_rst_pending", 32'(bus.cfg_pending_all), 32'h0);

    // Port 0 weight 3, one idle cycle, six grants to IVC0
    write_w(0, 4'd3);
    step();
    bus.cfg_wr_en = '0;
    check("p0_wr_pending", 32'(bus.cfg_pending_all[0]), 32'd1);
    check("p0_wr_cons_old", 32'(bus.iport_weight_is_consumed_all[0]), 32'd1);
    step();
    check("p0_swap_pending", 32'(bus.cfg_pending_all[0]), 32'd0);
    check("p0_swap_cons", 32'(bus.iport_weight_is_consumed_all[0]), 32'd0);
    bus.ivc_num_getting_sw_grant[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("p0_cons_g%0d", i+1), 32'(bus.iport_weight_is_consumed_all[0]), 32'(pc0_cons_exp[i]));
      check($sformatf("vc0_cons_g%0d", i+1), 32'(bus.vc_weight_is_consumed_all[0]), 32'(vc0_cons_exp[i]));
      step();
    end
    bus.ivc_num_getting_sw_grant = '0;
    check("p0_cons_end", 32'(bus.iport_weight_is_consumed_all[0]), 32'd0);

    // Two grant bits in one port count once; each IVC advances on its own
    bus.ivc_num_getting_sw_grant[1:0] = 2'b11;
    step();
    check("p0_multi_cons", 32'(bus.iport_weight_is_consumed_all[0]), 32'd0);
    check("p0_multi_vc", 32'(bus.vc_weight_is_consumed_all[1:0]), 32'h3);
    bus.ivc_num_getting_sw_grant[1:0] = 2'b01;
    step();
    check("p0_single_cons", 32'(bus.iport_weight_is_consumed_all[0]), 32'd1);
    check("p0_single_vc", 32'(bus.vc_weight_is_consumed_all[1:0]), 32'h2);
    step();
    bus.ivc_num_getting_sw_grant = '0;

    // Port 1: weight 4, advance to pc=2, then write 2 mid-round
    write_w(1, 4'd4);
    step();
    bus.cfg_wr_en = '0;
    step();
    check("p1_w4_cons", 32'(bus.iport_weight_is_consumed_all[1]), 32'd0);
    bus.ivc_num_getting_sw_grant[4] = 1'b1;
    step();
    step();
    bus.ivc_num_getting_sw_grant = '0;
    check("p1_pc2_cons", 32'(bus.iport_weight_is_consumed_all[1]), 32'd0);
    write_w(1, 4'd2);
    step();
    bus.cfg_wr_en = '0;
    check("p1_mid_pending", 32'(bus.cfg_pending_all[1]), 32'd1);
    step();
    check("p1_mid_pending_hold", 32'(bus.cfg_pending_all[1]), 32'd1);
    bus.ivc_num_getting_sw_grant[4] = 1'b1;
    step();
    check("p1_pc3_pending", 32'(bus.cfg_pending_all[1]), 32'd1);
    check("p1_pc3_cons", 32'(bus.iport_weight_is_consumed_all[1]), 32'd1);
    step();
    check("p1_bnd_pending", 32'(bus.cfg_pending_all[1]), 32'd0);
    check("p1_bnd_cons", 32'(bus.iport_weight_is_consumed_all[1]), 32'd0);
    step();
    check("p1_w2_cons", 32'(bus.iport_weight_is_consumed_all[1]), 32'd1);

    // Write landing on a boundary applies the new weight (5) there
    write_w(1, 4'd5);
    step();
    bus.cfg_wr_en = '0;
    bus.ivc_num_getting_sw_grant = '0;
    check("p1_wrbnd_pending", 32'(bus.cfg_pending_all[1]), 32'd0);
    check("p1_wrbnd_cons", 32'(bus.iport_weight_is_consumed_all[1]), 32'd0);
    bus.ivc_num_getting_sw_grant[4] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("p1_w5_cons_g%0d", i+1), 32'(bus.iport_weight_is_consumed_all[1]), 32'(p1_cons_exp[i]));
    end
    bus.ivc_num_getting_sw_grant = '0;

    // vc_weight 3 on port 2 IVC2, then drop to 1
    bus.vc_weight = 4'd3;
    #1;
    bus.ivc_num_getting_sw_grant[10] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("vc10_cons_g%0d", i+1), 32'(bus.vc_weight_is_consumed_all[10]), 32'(vc10_exp[i]));
      step();
    end
    check("vc10_wrap", 32'(bus.vc_weight_is_consumed_all[10]), 32'd0);
    step();
    bus.ivc_num_getting_sw_grant = '0;
    bus.vc_weight = 4'd1;
    #1;
    check("vc10_drop_cnt1", 32'(bus.vc_weight_is_consumed_all[10]), 32'd0);
    check("vc11_drop_now", 32'(bus.vc_weight_is_consumed_all[11]), 32'd1);
    step();
    check("vc10_drop_clear", 32'(bus.vc_weight_is_consumed_all[10]), 32'd1);
    bus.vc_weight = 4'd2;

    // Port 3: weight 3 then weight 0, which acts as 1
    write_w(3, 4'd3);
    step();
    bus.cfg_wr_en = '0;
    step();
    check("p3_w3_cons", 32'(bus.iport_weight_is_consumed_all[3]), 32'd0);
    write_w(3, 4'd0);
    step();
    bus.cfg_wr_en = '0;
    step();
    check("p3_w0_pending", 32'(bus.cfg_pending_all[3]), 32'd0);
    check("p3_w0_cons", 32'(bus.iport_weight_is_consumed_all[3]), 32'd1);
    bus.ivc_num_getting_sw_grant[12] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("p3_w0_cons_g%0d", i+1), 32'(bus.iport_weight_is_consumed_all[3]), 32'd1);
    end
    bus.ivc_num_getting_sw_grant = '0;

    // Port 4: weight 4, pc=2, one cycle with no requests, then one grant
    write_w(4, 4'd4);
    step();
    bus.cfg_wr_en = '0;
    step();
    bus.ivc_num_getting_sw_grant[16] = 1'b1;
    step();
    step();
    bus.ivc_num_getting_sw_grant = '0;
    check("p4_pc2_cons", 32'(bus.iport_weight_is_consumed_all[4]), 32'd0);
    bus.ivc_request_all[19:16] = 4'b0000;
    step();
    bus.ivc_request_all = '1;
    bus.ivc_num_getting_sw_grant[16] = 1'b1;
    step();
    bus.ivc_num_getting_sw_grant = '0;
`ifdef WRRA_IDLE_RESET_EN
    check("p4_idle_cons", 32'(bus.iport_weight_is_consumed_all[4]), 32'd0);
`else
    check("p4_idle_cons", 32'(bus.iport_weight_is_consumed_all[4]), 32'd1);
`endif

    // Reset while a weight is pending discards it
    write_w(2, 4'd6);
    step();
    bus.cfg_wr_en = '0;
    check("p2_pending", 32'(bus.cfg_pending_all[2]), 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_pending", 32'(bus.cfg_pending_all), 32'h0);
    check("mid_rst_iport_cons", 32'(bus.iport_weight_is_consumed_all), 32'h1f);
    check("mid_rst_vc_cons", 32'(bus.vc_weight_is_consumed_all), 32'h0);
    step();
    reset = 1'b1;
    step();
    step();
    check("after_rst_pending", 32'(bus.cfg_pending_all), 32'h0);
    check("after_rst_iport_cons", 32'(bus.iport_weight_is_consumed_all), 32'h1f);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
